// File: rtl/decoder_nxm_pipe_pkg.sv
// Shared decoder definitions: mode encoding and default widths used across the
// decoder family.
package decoder_nxm_pipe_pkg;

    typedef enum logic {
        MODE_ONEHOT = 1'b0,
        MODE_THERMO = 1'b1
    } mode_e;

    localparam int unsigned DEF_IN_WIDTH  = 6;
    localparam int unsigned DEF_OUT_WIDTH = 20;
    localparam int unsigned DEF_ERR_WIDTH = 8;

endpackage

// File: rtl/decoder_nxm_pipe_core.sv
// Combinational code-to-word decoder (one-hot or thermometer) with an
// out-of-range flag for codes that have no output line.
module decoder_core
    import decoder_nxm_pipe_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic [IN_WIDTH-1:0]  coder,
    input  logic                 mode,
    output logic [OUT_WIDTH-1:0] word,
    output logic                 oor
);

    logic hit;

    // Every line index fits in IN_WIDTH bits, so comparisons happen at the
    // code's own width with no truncation of coder.
    always_comb begin
        word = '0;
        hit  = 1'b0;
        for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
            if (IN_WIDTH'(i) == coder) begin
                hit = 1'b1;
            end
            if (mode_e'(mode) == MODE_THERMO) begin
                word[i] = (IN_WIDTH'(i) <= coder);
            end else begin
                word[i] = (IN_WIDTH'(i) == coder);
            end
        end
        if (!hit) begin
            word = '0;
        end
        oor = !hit;
    end

endmodule

// File: rtl/decoder_nxm_pipe.sv
// Registered N-to-M decoder with valid/ready handshake on both sides and a
// saturating count of accepted out-of-range codes.
module decoder_nxm_pipe
    import decoder_nxm_pipe_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int unsigned ERR_WIDTH = DEF_ERR_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  coder,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] decoder,
    output logic                 out_of_range,
    output logic [ERR_WIDTH-1:0] error_count,
    input  logic                 clear_errors
);

    if (OUT_WIDTH == 0 || longint'(OUT_WIDTH) > (longint'(1) << IN_WIDTH)) begin : g_bad_width
        $error("decoder_nxm_pipe: OUT_WIDTH must be in 1..2**IN_WIDTH");
    end

    logic [OUT_WIDTH-1:0] word;
    logic                 oor;
    logic                 accept;

    decoder_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .coder (coder),
        .mode  (mode),
        .word  (word),
        .oor   (oor)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            decoder      <= '0;
            out_of_range <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            decoder      <= word;
            out_of_range <= oor;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            error_count <= '0;
        end else if (clear_errors) begin
            error_count <= '0;
        end else if (accept && oor && (error_count != '1)) begin
            error_count <= error_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_decoder_nxm_pipe.sv
// Self-checking bench for decoder_nxm_pipe: default, ERR_WIDTH=2 and 3-to-8
// instances share one stimulus stream and are checked against a reference.
module tb_decoder_nxm_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [5:0] coder;
    logic       mode;
    logic       out_ready;
    logic       clear_errors;

    logic        ir0, ov0, oor0;
    logic [19:0] dec0;
    logic [7:0]  err0;
    logic        ir1, ov1, oor1;
    logic [19:0] dec1;
    logic [1:0]  err1;
    logic        ir2, ov2, oor2;
    logic [7:0]  dec2;
    logic [7:0]  err2;

    decoder_nxm_pipe dut0 (
        .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir0),
        .coder(coder), .mode(mode), .out_valid(ov0), .out_ready(out_ready),
        .decoder(dec0), .out_of_range(oor0), .error_count(err0),
        .clear_errors(clear_errors)
    );

    decoder_nxm_pipe #(.ERR_WIDTH(2)) dut1 (
        .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir1),
        .coder(coder), .mode(mode), .out_valid(ov1), .out_ready(out_ready),
        .decoder(dec1), .out_of_range(oor1), .error_count(err1),
        .clear_errors(clear_errors)
    );

    decoder_nxm_pipe #(.IN_WIDTH(3), .OUT_WIDTH(8)) dut2 (
        .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir2),
        .coder(coder[2:0]), .mode(mode), .out_valid(ov2), .out_ready(out_ready),
        .decoder(dec2), .out_of_range(oor2), .error_count(err2),
        .clear_errors(clear_errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: one shared valid bit, per-instance result and count.
    bit          mv;
    logic [63:0] mw [3];
    bit          moor [3];
    int          merr [3];
    int          wid  [3] = '{20, 20, 8};
    int          emax [3] = '{255, 3, 255};
    int          cmask[3] = '{63, 63, 7};

    typedef struct {
        bit          v;
        logic [5:0]  c;
        bit          m;
        bit          r;
        logic [19:0] dec;
        bit          oor;
        bit          val;
    } vec_t;
    vec_t tv [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_word(input int code, input bit m, input int w);
        if (code >= w) return 64'd0;
        return m ? ((64'd1 << (code + 1)) - 64'd1) : (64'd1 << code);
    endfunction

    task automatic model_reset();
        mv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mw[k] = '0; moor[k] = 1'b0; merr[k] = 0;
        end
    endtask

    task automatic compare_all();
        chk("out_valid0", 64'(ov0), 64'(mv));
        chk("out_valid1", 64'(ov1), 64'(mv));
        chk("out_valid2", 64'(ov2), 64'(mv));
        if (mv) begin
            chk("decoder0", 64'(dec0), mw[0]);
            chk("decoder1", 64'(dec1), mw[1]);
            chk("decoder2", 64'(dec2), mw[2]);
            chk("oor0", 64'(oor0), 64'(moor[0]));
            chk("oor1", 64'(oor1), 64'(moor[1]));
            chk("oor2", 64'(oor2), 64'(moor[2]));
        end
        chk("err0", 64'(err0), 64'(merr[0]));
        chk("err1", 64'(err1), 64'(merr[1]));
        chk("err2", 64'(err2), 64'(merr[2]));
    endtask

    task automatic cyc(input bit v, input logic [5:0] c, input bit m, input bit r, input bit clr);
        bit acc;
        int code;
        in_valid = v; coder = c; mode = m; out_ready = r; clear_errors = clr;
        #1;
        chk("in_ready0", 64'(ir0), 64'(!mv || r));
        chk("in_ready2", 64'(ir2), 64'(!mv || r));
        acc = v && (!mv || r);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            code = int'(c) & cmask[k];
            if (clr) merr[k] = 0;
            else if (acc && code >= wid[k] && merr[k] < emax[k]) merr[k]++;
            if (acc) begin
                mw[k]   = ref_word(code, m, wid[k]);
                moor[k] = (code >= wid[k]);
            end
        end
        if (acc) mv = 1'b1;
        else if (r) mv = 1'b0;
        #1;
        compare_all();
    endtask

    initial begin
        tv[0]  = '{1'b1, 6'd5,  1'b0, 1'b1, 20'h00020, 1'b0, 1'b1};
        tv[1]  = '{1'b1, 6'd19, 1'b0, 1'b1, 20'h80000, 1'b0, 1'b1};
        tv[2]  = '{1'b1, 6'd20, 1'b0, 1'b1, 20'h00000, 1'b1, 1'b1};
        tv[3]  = '{1'b1, 6'd0,  1'b1, 1'b1, 20'h00001, 1'b0, 1'b1};
        tv[4]  = '{1'b1, 6'd7,  1'b1, 1'b1, 20'h000FF, 1'b0, 1'b1};
        tv[5]  = '{1'b1, 6'd19, 1'b1, 1'b1, 20'hFFFFF, 1'b0, 1'b1};
        tv[6]  = '{1'b1, 6'd20, 1'b1, 1'b1, 20'h00000, 1'b1, 1'b1};
        tv[7]  = '{1'b1, 6'd3,  1'b0, 1'b1, 20'h00008, 1'b0, 1'b1};
        tv[8]  = '{1'b1, 6'd9,  1'b0, 1'b0, 20'h00008, 1'b0, 1'b1};
        tv[9]  = '{1'b1, 6'd9,  1'b1, 1'b0, 20'h00008, 1'b0, 1'b1};
        tv[10] = '{1'b1, 6'd9,  1'b0, 1'b0, 20'h00008, 1'b0, 1'b1};
        tv[11] = '{1'b1, 6'd9,  1'b0, 1'b1, 20'h00200, 1'b0, 1'b1};
        tv[12] = '{1'b0, 6'd0,  1'b0, 1'b1, 20'h00200, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 0; coder = '0; mode = 0; out_ready = 0; clear_errors = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ov0), 64'd0);
        chk("rst_decoder", 64'(dec0), 64'd0);
        chk("rst_oor", 64'(oor0), 64'd0);
        chk("rst_err", 64'(err0), 64'd0);
        chk("rst_in_ready", 64'(ir0), 64'd1);
        rst = 1'b0;

        // One-hot sweep across the whole code space.
        for (int i = 0; i < 64; i++) cyc(1'b1, 6'(i), 1'b0, 1'b1, 1'b0);
        chk("sweep_err0", 64'(err0), 64'd44);
        chk("sweep_err1_sat", 64'(err1), 64'd3);
        chk("sweep_err2", 64'(err2), 64'd0);

        for (int i = 0; i < 13; i++) begin
            cyc(tv[i].v, tv[i].c, tv[i].m, tv[i].r, 1'b0);
            chk($sformatf("tv%0d_decoder", i), 64'(dec0), 64'(tv[i].dec));
            chk($sformatf("tv%0d_oor", i), 64'(oor0), 64'(tv[i].oor));
            chk($sformatf("tv%0d_valid", i), 64'(ov0), 64'(tv[i].val));
            if (i >= 8 && i <= 10) chk($sformatf("tv%0d_stall_ready", i), 64'(ir0), 64'd0);
        end

        // Asynchronous reset while a result is held under backpressure.
        cyc(1'b1, 6'd10, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 6'd11, 1'b0, 1'b0, 1'b0);
        chk("held_0x400", 64'(dec0), 64'h400);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_valid", 64'(ov0), 64'd0);
        chk("midrst_decoder", 64'(dec0), 64'd0);
        chk("midrst_err", 64'(err0), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 6'd1, 1'b0, 1'b1, 1'b0);
        chk("post_rst_code1", 64'(dec0), 64'h2);

        // Saturation and clear-over-increment on the 2-bit counter.
        cyc(1'b0, 6'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 6'(20 + i), 1'b0, 1'b1, 1'b0);
        chk("sat_err1", 64'(err1), 64'd3);
        cyc(1'b1, 6'd30, 1'b0, 1'b1, 1'b1);
        chk("clear_prio_err1", 64'(err1), 64'd0);
        chk("clear_prio_err0", 64'(err0), 64'd0);
        chk("clear_datapath_oor", 64'(oor0), 64'd1);

        cyc(1'b1, 6'd7, 1'b1, 1'b1, 1'b0);
        chk("n3m8_thermo7", 64'(dec2), 64'hFF);
        chk("n3m8_oor", 64'(oor2), 64'd0);

        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
                1'($urandom_range(0, 29) == 0));
        end
        cyc(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
